// File: rtl/spi_slave_pkg.sv
// ============================================================================
//  spi_pkg : shared types and constants for the SPI slave
//  Frame is 10 bits: [9:8] command, [7:0] address/data.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_pkg;

    localparam int FRAME_W = 10;
    localparam int DATA_W  = 8;

    localparam logic [3:0] BIT_CNT_MAX = 4'd10;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } spi_state_t;

    // Only the command MSB and the read-address history pick the frame state.
    function automatic spi_state_t cmd_state(input logic cmd_msb, input logic rd_addr_done);
        if (!cmd_msb)
            return WRITE;
        else if (rd_addr_done)
            return READ_DATA;
        else
            return READ_ADD;
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_slave_if.sv
// ============================================================================
//  spi_slave_if : SPI pins plus the receive/transmit side-band of the slave
//  Optional err signal exists only when SPI_SLAVE_ERR_EN is defined.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface spi_slave_if;
    import spi_pkg::*;

    logic               SS_n;
    logic               MOSI;
    logic               MISO;
    logic [FRAME_W-1:0] rx_data;
    logic               rx_valid;
    logic [DATA_W-1:0]  tx_data;
    logic               tx_valid;
`ifdef SPI_SLAVE_ERR_EN
    logic               err;
`endif

    modport slave (
        input  SS_n, MOSI, tx_data, tx_valid,
`ifdef SPI_SLAVE_ERR_EN
        output err,
`endif
        output MISO, rx_data, rx_valid
    );

    modport master (
        output SS_n, MOSI, tx_data, tx_valid,
`ifdef SPI_SLAVE_ERR_EN
        input  err,
`endif
        input  MISO, rx_data, rx_valid
    );

endinterface

`default_nettype wire

// File: rtl/spi_slave_tx_serializer.sv
// ============================================================================
//  spi_tx_serializer : loads one read-data byte and shifts it out on MISO,
//  MSB first, one bit per clock; MISO returns to MISO_IDLE afterwards.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_tx_serializer #(
    parameter logic MISO_IDLE = 1'b0,
    parameter int   DATA_W    = 8
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              clear,
    input  wire logic              load,
    input  wire logic [DATA_W-1:0] data,
    output logic                   miso,
    output logic                   busy
);

    // Holds the bits still to be sent after the one currently on MISO.
    logic [DATA_W-2:0] shreg;
    logic [3:0]        remaining;

    assign busy = (remaining != 4'd0);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            shreg     <= '0;
            remaining <= 4'd0;
            miso      <= MISO_IDLE;
        end else if (load && !busy) begin
            shreg     <= data[DATA_W-2:0];
            remaining <= 4'(DATA_W);
            miso      <= data[DATA_W-1];
        end else if (busy) begin
            if (remaining > 4'd1) begin
                miso  <= shreg[DATA_W-2];
                shreg <= {shreg[DATA_W-3:0], 1'b0};
            end else begin
                miso  <= MISO_IDLE;
            end
            remaining <= remaining - 4'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/spi_slave.sv
// ============================================================================
//  spi_slave : 10-bit frame SPI slave with write, read-address and read-data
//  transactions. Optional macro SPI_SLAVE_ERR_EN adds an abort error flag.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_slave
    import spi_pkg::*;
#(
    parameter logic MISO_IDLE = 1'b0
) (
    input  wire logic clk,
    input  wire logic rst_n,
    spi_slave_if.slave bus
);

    spi_state_t         state;
    logic [3:0]         bit_cnt;
    logic [FRAME_W-2:0] shreg;
    logic [FRAME_W-1:0] rx_data;
    logic               rx_valid;
    logic               rd_addr_done;
    logic               tx_started;
    logic               tx_load;
    logic               tx_busy;
    logic               abort;
    logic               miso;
`ifdef SPI_SLAVE_ERR_EN
    logic               err;
`endif

    assign abort   = (state != IDLE) && bus.SS_n;
    // Read data is accepted once per READ_DATA frame, only after the frame is in.
    assign tx_load = (state == READ_DATA) && (bit_cnt == BIT_CNT_MAX) &&
                     !tx_started && bus.tx_valid && !bus.SS_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            bit_cnt      <= 4'd0;
            shreg        <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rd_addr_done <= 1'b0;
            tx_started   <= 1'b0;
`ifdef SPI_SLAVE_ERR_EN
            err          <= 1'b0;
`endif
        end else begin
            rx_valid <= 1'b0;
            if (abort) begin
                state      <= IDLE;
                bit_cnt    <= 4'd0;
                tx_started <= 1'b0;
`ifdef SPI_SLAVE_ERR_EN
                err        <= ((bit_cnt != 4'd0) && (bit_cnt < BIT_CNT_MAX)) || tx_busy;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        if (!bus.SS_n) begin
                            state   <= CHK_CMD;
                            bit_cnt <= 4'd0;
`ifdef SPI_SLAVE_ERR_EN
                            err     <= 1'b0;
`endif
                        end
                    end
                    CHK_CMD: begin
                        shreg   <= {shreg[FRAME_W-3:0], bus.MOSI};
                        bit_cnt <= 4'd1;
                        state   <= cmd_state(bus.MOSI, rd_addr_done);
                    end
                    WRITE, READ_ADD, READ_DATA: begin
                        if (bit_cnt < BIT_CNT_MAX) begin
                            shreg   <= {shreg[FRAME_W-3:0], bus.MOSI};
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == BIT_CNT_MAX - 4'd1) begin
                                rx_data  <= {shreg, bus.MOSI};
                                rx_valid <= 1'b1;
                                if (state == READ_ADD)
                                    rd_addr_done <= 1'b1;
                                else if (state == READ_DATA)
                                    rd_addr_done <= 1'b0;
                            end
                        end else if (tx_load) begin
                            tx_started <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    spi_tx_serializer #(
        .MISO_IDLE (MISO_IDLE),
        .DATA_W    (DATA_W)
    ) u_tx (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (abort),
        .load  (tx_load),
        .data  (bus.tx_data),
        .miso  (miso),
        .busy  (tx_busy)
    );

    assign bus.MISO     = miso;
    assign bus.rx_data  = rx_data;
    assign bus.rx_valid = rx_valid;
`ifdef SPI_SLAVE_ERR_EN
    assign bus.err      = err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_spi_slave.sv
// ============================================================================
//  tb_spi_slave : directed self-checking bench for spi_slave
//  Checks under SPI_SLAVE_ERR_EN also cover the err output.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_slave;
    import spi_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    spi_slave_if bus ();

    spi_slave #(.MISO_IDLE(1'b0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Drives a full frame; returns the edge index (0 = SS_n fall edge) where rx_valid appeared.
    task automatic shift_frame(input logic [9:0] f, output int ve);
        ve = -1;
        @(negedge clk);
        bus.SS_n = 1'b0;
        bus.MOSI = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.rx_valid === 1'b1 && ve < 0) ve = k;
            if (k < 10) bus.MOSI = f[9-k];
        end
    endtask

    task automatic end_frame();
        bus.SS_n = 1'b1;
        bus.MOSI = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.SS_n = 1'b0;
        bus.tx_valid = 1'b1;
        bus.tx_data = 8'hFF;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (dut.state !== IDLE) begin fails++; $display("FAIL reset_state: got %0d expected %0d", dut.state, IDLE); end
        checks++; if (bus.rx_data !== 10'h000) begin fails++; $display("FAIL reset_rx_data: got %h expected 000", bus.rx_data); end
        checks++; if (bus.rx_valid !== 1'b0) begin fails++; $display("FAIL reset_rx_valid: got %b expected 0", bus.rx_valid); end
        checks++; if (bus.MISO !== 1'b0) begin fails++; $display("FAIL reset_miso: got %b expected 0", bus.MISO); end
        checks++; if (dut.rd_addr_done !== 1'b0) begin fails++; $display("FAIL reset_rd_addr_done: got %b expected 0", dut.rd_addr_done); end
        bus.SS_n = 1'b1;
        bus.tx_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write();
        int ve;
        shift_frame(10'h0AA, ve);
        checks++; if (ve !== 10) begin fails++; $display("FAIL write_latency: got edge %0d expected 10", ve); end
        checks++; if (bus.rx_data !== 10'h0AA) begin fails++; $display("FAIL write_rx_data: got %h expected 0aa", bus.rx_data); end
        checks++; if (dut.state !== WRITE) begin fails++; $display("FAIL write_state: got %0d expected %0d", dut.state, WRITE); end
        for (int i = 0; i < 4; i++) begin
            bus.MOSI = ~bus.MOSI;
            @(negedge clk);
            checks++; if (bus.rx_valid !== 1'b0) begin fails++; $display("FAIL write_single_strobe: got rx_valid %b expected 0 (cycle %0d)", bus.rx_valid, i); end
        end
        checks++; if (bus.rx_data !== 10'h0AA) begin fails++; $display("FAIL write_hold: got %h expected 0aa", bus.rx_data); end
        checks++; if (dut.bit_cnt !== 4'd10) begin fails++; $display("FAIL write_cnt_saturate: got %0d expected 10", dut.bit_cnt); end
        end_frame();
        checks++; if (dut.state !== IDLE) begin fails++; $display("FAIL write_end_idle: got %0d expected %0d", dut.state, IDLE); end
    endtask

    task automatic test_write_read_addr();
        int ve;
        shift_frame(10'h155, ve);
        checks++; if (ve !== 10) begin fails++; $display("FAIL wr155_latency: got edge %0d expected 10", ve); end
        checks++; if (bus.rx_data !== 10'h155) begin fails++; $display("FAIL wr155_rx_data: got %h expected 155", bus.rx_data); end
        checks++; if (dut.rd_addr_done !== 1'b0) begin fails++; $display("FAIL wr155_rd_addr_done: got %b expected 0", dut.rd_addr_done); end
        end_frame();
        shift_frame(10'h2AA, ve);
        checks++; if (ve !== 10) begin fails++; $display("FAIL rdaddr_latency: got edge %0d expected 10", ve); end
        checks++; if (bus.rx_data !== 10'h2AA) begin fails++; $display("FAIL rdaddr_rx_data: got %h expected 2aa", bus.rx_data); end
        checks++; if (dut.rd_addr_done !== 1'b1) begin fails++; $display("FAIL rdaddr_rd_addr_done: got %b expected 1", dut.rd_addr_done); end
        checks++; if (dut.state !== READ_ADD) begin fails++; $display("FAIL rdaddr_state: got %0d expected %0d", dut.state, READ_ADD); end
        bus.tx_data = 8'hFF;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.MISO !== 1'b0) begin fails++; $display("FAIL rdaddr_tx_ignored: got MISO %b expected 0", bus.MISO); end
        end_frame();
    endtask

    task automatic test_read_data();
        int ve;
        logic [7:0] exp;
        exp = 8'hC5;
        shift_frame(10'h300, ve);
        checks++; if (ve !== 10) begin fails++; $display("FAIL rddata_latency: got edge %0d expected 10", ve); end
        checks++; if (bus.rx_data !== 10'h300) begin fails++; $display("FAIL rddata_rx_data: got %h expected 300", bus.rx_data); end
        checks++; if (dut.rd_addr_done !== 1'b0) begin fails++; $display("FAIL rddata_rd_addr_done: got %b expected 0", dut.rd_addr_done); end
        checks++; if (dut.state !== READ_DATA) begin fails++; $display("FAIL rddata_state: got %0d expected %0d", dut.state, READ_DATA); end
        repeat (2) @(negedge clk);
        checks++; if (bus.MISO !== 1'b0) begin fails++; $display("FAIL rddata_wait_idle: got MISO %b expected 0", bus.MISO); end
        bus.tx_data = exp;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        checks++; if (bus.MISO !== exp[7]) begin fails++; $display("FAIL rddata_bit7: got %b expected %b", bus.MISO, exp[7]); end
        for (int b = 6; b >= 0; b--) begin
            if (b == 4) begin
                bus.tx_data = 8'h00;
                bus.tx_valid = 1'b1;
            end
            @(negedge clk);
            bus.tx_valid = 1'b0;
            checks++; if (bus.MISO !== exp[b]) begin fails++; $display("FAIL rddata_bit%0d: got %b expected %b", b, bus.MISO, exp[b]); end
        end
        @(negedge clk);
        checks++; if (bus.MISO !== 1'b0) begin fails++; $display("FAIL rddata_after_idle: got %b expected 0", bus.MISO); end
        bus.tx_data = 8'hFF;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.MISO !== 1'b0) begin fails++; $display("FAIL rddata_second_tx_ignored: got %b expected 0", bus.MISO); end
        end_frame();
    endtask

    task automatic test_abort();
        int ve;
        logic [4:0] bits;
        bits = 5'b10110;
        shift_frame(10'h2AA, ve);
        end_frame();
        @(negedge clk);
        bus.SS_n = 1'b0;
        bus.MOSI = 1'b0;
        @(posedge clk);
        for (int k = 4; k >= 0; k--) begin
            @(negedge clk);
            bus.MOSI = bits[k];
            @(posedge clk);
        end
        @(negedge clk);
        checks++; if (dut.bit_cnt !== 4'd5) begin fails++; $display("FAIL abort_bits_in: got %0d expected 5", dut.bit_cnt); end
        bus.SS_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (bus.rx_valid !== 1'b0) begin fails++; $display("FAIL abort_no_valid: got %b expected 0", bus.rx_valid); end
        checks++; if (dut.state !== IDLE) begin fails++; $display("FAIL abort_idle: got %0d expected %0d", dut.state, IDLE); end
        checks++; if (dut.rd_addr_done !== 1'b1) begin fails++; $display("FAIL abort_rd_kept: got %b expected 1", dut.rd_addr_done); end
        checks++; if (bus.rx_data !== 10'h2AA) begin fails++; $display("FAIL abort_rx_hold: got %h expected 2aa", bus.rx_data); end
        checks++; if (dut.bit_cnt !== 4'd0) begin fails++; $display("FAIL abort_cnt_clear: got %0d expected 0", dut.bit_cnt); end
`ifdef SPI_SLAVE_ERR_EN
        checks++; if (bus.err !== 1'b1) begin fails++; $display("FAIL abort_err_set: got %b expected 1", bus.err); end
`endif
        bus.SS_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (dut.state !== CHK_CMD) begin fails++; $display("FAIL abort_restart: got %0d expected %0d", dut.state, CHK_CMD); end
`ifdef SPI_SLAVE_ERR_EN
        checks++; if (bus.err !== 1'b0) begin fails++; $display("FAIL abort_err_clear: got %b expected 0", bus.err); end
`endif
        bus.SS_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
`ifdef SPI_SLAVE_ERR_EN
        checks++; if (bus.err !== 1'b0) begin fails++; $display("FAIL abort_zero_bits_no_err: got %b expected 0", bus.err); end
`endif
        checks++; if (dut.state !== IDLE) begin fails++; $display("FAIL abort_chk_idle: got %0d expected %0d", dut.state, IDLE); end
    endtask

    task automatic test_reset_during_shift();
        int ve;
        shift_frame(10'h3C3, ve);
        checks++; if (bus.rx_data !== 10'h3C3) begin fails++; $display("FAIL rst_shift_rx_data: got %h expected 3c3", bus.rx_data); end
        bus.tx_data = 8'hFF;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.MISO !== 1'b1) begin fails++; $display("FAIL rst_shift_pre: got MISO %b expected 1", bus.MISO); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (bus.MISO !== 1'b0) begin fails++; $display("FAIL rst_shift_miso: got %b expected 0", bus.MISO); end
        checks++; if (dut.rd_addr_done !== 1'b0) begin fails++; $display("FAIL rst_shift_rd: got %b expected 0", dut.rd_addr_done); end
        checks++; if (dut.state !== IDLE) begin fails++; $display("FAIL rst_shift_state: got %0d expected %0d", dut.state, IDLE); end
        bus.SS_n = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        shift_frame(10'h2AA, ve);
        end_frame();
        checks++; if (dut.rd_addr_done !== 1'b1) begin fails++; $display("FAIL rst_mid_pre_rd: got %b expected 1", dut.rd_addr_done); end
        bus.SS_n = 1'b0;
        bus.MOSI = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (bus.rx_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_no_valid: got %b expected 0", bus.rx_valid); end
        checks++; if (dut.rd_addr_done !== 1'b0) begin fails++; $display("FAIL rst_mid_rd: got %b expected 0", dut.rd_addr_done); end
        checks++; if (bus.rx_data !== 10'h000) begin fails++; $display("FAIL rst_mid_rx_data: got %h expected 000", bus.rx_data); end
        bus.SS_n = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_rd_without_addr();
        int ve;
        shift_frame(10'h3A5, ve);
        checks++; if (ve !== 10) begin fails++; $display("FAIL rdnoaddr_latency: got edge %0d expected 10", ve); end
        checks++; if (bus.rx_data !== 10'h3A5) begin fails++; $display("FAIL rdnoaddr_rx_data: got %h expected 3a5", bus.rx_data); end
        checks++; if (dut.state !== READ_ADD) begin fails++; $display("FAIL rdnoaddr_state: got %0d expected %0d", dut.state, READ_ADD); end
        checks++; if (dut.rd_addr_done !== 1'b1) begin fails++; $display("FAIL rdnoaddr_rd: got %b expected 1", dut.rd_addr_done); end
        end_frame();
    endtask

    task automatic test_back_to_back();
        int ve;
        shift_frame(10'h1F0, ve);
        checks++; if (ve !== 10 || bus.rx_data !== 10'h1F0) begin fails++; $display("FAIL b2b_first: got edge %0d data %h expected edge 10 data 1f0", ve, bus.rx_data); end
        end_frame();
        shift_frame(10'h00F, ve);
        checks++; if (ve !== 10 || bus.rx_data !== 10'h00F) begin fails++; $display("FAIL b2b_second: got edge %0d data %h expected edge 10 data 00f", ve, bus.rx_data); end
        checks++; if (dut.rd_addr_done !== 1'b1) begin fails++; $display("FAIL b2b_rd_kept: got %b expected 1", dut.rd_addr_done); end
        end_frame();
    endtask

    initial begin
        bus.SS_n     = 1'b1;
        bus.MOSI     = 1'b0;
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;
        test_reset();
        test_write();
        test_write_read_addr();
        test_read_data();
        test_abort();
        test_reset_during_shift();
        test_rd_without_addr();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter: MISO_IDLE, default 1'b0, level driven on MISO when not transmitting read data.
REQ-002 clk  input  1  system and SPI bit clock; all sampling on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 SS_n  input  1  slave select, active-low; low frames a transaction.
REQ-005 MOSI  input  1  serial data in, MSB first.
REQ-006 MISO  output  1  serial data out, MSB first.
REQ-007 rx_data  output  10  received frame; [9:8] command, [7:0] address/data.
REQ-008 rx_valid  output  1  one-cycle strobe, rx_data valid.
REQ-009 tx_data  input  8  read data from downstream memory.
REQ-010 tx_valid  input  1  tx_data valid strobe.

Function
REQ-011 States SHALL be IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
REQ-012 IDLE: SS_n low at an edge -> CHK_CMD; MOSI at that edge ignored.
REQ-013 CHK_CMD: MOSI sampled as rx bit 9; 0 -> WRITE; 1 and rd_addr_done=0 -> READ_ADD; 1 and rd_addr_done=1 -> READ_DATA.
REQ-014 WRITE/READ_ADD/READ_DATA: next 9 edges sample bits 8..0 into a shift register, MSB first; bit 9 counts as bit 1 of 10.
REQ-015 After the edge sampling bit 0, rx_data SHALL update and rx_valid SHALL be high for exactly one cycle; rx_data holds until next frame completes.
REQ-016 rx_data[9:8] forwarded as received; state selection uses only bit 9 and rd_addr_done.
REQ-017 rd_addr_done set on READ_ADD frame completion, cleared on READ_DATA frame completion.
REQ-018 READ_DATA after rx_valid: wait for tx_valid; on edge sampling tx_valid=1, capture tx_data, drive MISO=tx_data[7]; next 7 edges shift bits 6..0; then MISO=MISO_IDLE.
REQ-019 tx_valid outside READ_DATA wait phase, or during shift-out, SHALL be ignored.
REQ-020 After frame completion (and shift-out in READ_DATA) stay in state, sampling nothing, until SS_n high.
REQ-021 SS_n high at any edge in any non-IDLE state -> IDLE next cycle; bit counter cleared; no rx_valid for partial frame; rd_addr_done unchanged; MISO=MISO_IDLE.
REQ-022 Bit counter 4 bits, saturates at 10; no wrap.

Reset
REQ-023 rst_n low at edge: state IDLE, rx_data 0, rx_valid 0, MISO MISO_IDLE, rd_addr_done 0, counters 0; overrides SS_n and tx_valid.
REQ-024 Reset mid-frame SHALL abort it without rx_valid.

Configuration
REQ-025 Macro SPI_SLAVE_ERR_EN defined: output err (1 bit) added; set the cycle after SS_n rises with 1..9 bits received or during READ_DATA shift-out; cleared when SS_n next falls or on reset.
REQ-026 Macro undefined: no err port, abort behaviour otherwise identical.

Structure
REQ-027 Package spi_pkg SHALL hold state enum typedef, FRAME_W=10, DATA_W=8, command constants (00 WR_ADDR, 01 WR_DATA, 10 RD_ADDR, 11 RD_DATA).
REQ-028 One sub-module spi_tx_serializer (load, shift, MISO, busy) for MISO path.

Verification
REQ-029 SS_n low, MOSI 0_00_1010_1010 -> rx_valid one cycle, rx_data=10'h0AA, 11 edges after SS_n fall.
REQ-030 Write 10'h155 then read address 10'h2AA -> rx_data 10'h155 then 10'h2AA, rd_addr_done=1.
REQ-031 Read data 10'h300 with tx_valid pulse, tx_data=8'hC5 -> MISO 1,1,0,0,0,1,0,1 over next 8 cycles, then MISO_IDLE; rd_addr_done=0.
REQ-032 SS_n high after 5 bits -> no rx_valid, IDLE next cycle; err=1 with SPI_SLAVE_ERR_EN.
REQ-033 rst_n low during READ_DATA shift-out -> MISO=MISO_IDLE, rd_addr_done=0 next cycle.
REQ-034 Read-data command with rd_addr_done=0 -> READ_ADD path, rx_data=10'h3xx, rd_addr_done=1.
